sprite_rom_arbiter: RTL and testbench

//  Round-robin arbiter sharing one single-port sprite frame ROM (24-bit palette RGB out, 1-cycle registered read)

---
 rtl/sprite_rom_arbiter.sv | 135 +++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sprite_rom_arbiter
// Brief   : Round-robin arbiter sharing one sprite ROM among N_REQ draw units;
//           tags returned pixels with requester id and flags out-of-range
//           addresses. Optional macro TRANSPARENT_KEY_EN adds rsp_transp.
// Revision: 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int AW      = 19,
  parameter int DEPTH   = 1024,
  parameter int ROM_LAT = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*AW-1:0]        req_addr,
  output logic [N_REQ-1:0]           req_ready,
  output logic [AW-1:0]              rom_addr,
  input  logic [23:0]                rom_data,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [23:0]                rsp_data,
  output logic                       rsp_err
`ifdef TRANSPARENT_KEY_EN
  ,
  output logic                       rsp_transp
`endif
);

  localparam int          C_IDW        = $clog2(N_REQ);
  localparam logic [23:0] C_KEY_COLOUR = 24'hFF0000;

  logic [AW-1:0]    w_addr_arr [N_REQ];
  logic             w_grant_found;
  logic [C_IDW-1:0] w_grant_id;
  logic [AW-1:0]    w_sel_addr;
  logic             w_oor;

  logic [C_IDW-1:0] ptr_q, ptr_d;
  logic [AW-1:0]    last_addr_q, last_addr_d;
  logic             pipe_valid_q [ROM_LAT];
  logic             pipe_valid_d [ROM_LAT];
  logic [C_IDW-1:0] pipe_id_q    [ROM_LAT];
  logic [C_IDW-1:0] pipe_id_d    [ROM_LAT];
  logic             pipe_err_q   [ROM_LAT];
  logic             pipe_err_d   [ROM_LAT];

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = req_addr[gi*AW +: AW];
  end

  // Scan from ptr upward (mod N_REQ); no grants are issued while in reset.
  always_comb begin
    int idx;
    idx           = 0;
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!w_grant_found && req_valid[idx]) begin
        w_grant_found = 1'b1;
        w_grant_id    = C_IDW'(idx);
      end
    end
    w_grant_found = w_grant_found & ~Reset;
  end

  assign w_sel_addr = w_addr_arr[w_grant_id];
  assign w_oor      = (w_sel_addr >= AW'(DEPTH));

  always_comb begin
    req_ready = '0;
    if (w_grant_found) begin
      req_ready = N_REQ'(1) << w_grant_id;
    end
    rom_addr = w_grant_found ? w_sel_addr : last_addr_q;
  end

  always_comb begin
    last_addr_d = w_grant_found ? w_sel_addr : last_addr_q;
    ptr_d       = ptr_q;
    if (w_grant_found) begin
      ptr_d = (w_grant_id == C_IDW'(N_REQ - 1)) ? '0 : w_grant_id + C_IDW'(1);
    end
    if (frame_start) begin
      ptr_d = '0;
    end
  end

  always_comb begin
    pipe_valid_d[0] = w_grant_found;
    pipe_id_d[0]    = w_grant_id;
    pipe_err_d[0]   = w_grant_found & w_oor;
    for (int s = 1; s < ROM_LAT; s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_id_d[s]    = pipe_id_q[s-1];
      pipe_err_d[s]   = pipe_err_q[s-1];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q       <= '0;
      last_addr_q <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        pipe_valid_q[s] <= 1'b0;
        pipe_id_q[s]    <= '0;
        pipe_err_q[s]   <= 1'b0;
      end
    end else begin
      ptr_q       <= ptr_d;
      last_addr_q <= last_addr_d;
      for (int s = 0; s < ROM_LAT; s++) begin
        pipe_valid_q[s] <= pipe_valid_d[s];
        pipe_id_q[s]    <= pipe_id_d[s];
        pipe_err_q[s]   <= pipe_err_d[s];
      end
    end
  end

  assign rsp_valid = pipe_valid_q[ROM_LAT-1];
  assign rsp_id    = pipe_id_q[ROM_LAT-1];
  assign rsp_err   = pipe_err_q[ROM_LAT-1];
  assign rsp_data  = rsp_err ? 24'h000000 : rom_data;

`ifdef TRANSPARENT_KEY_EN
  assign rsp_transp = rsp_valid & ~rsp_err & (rom_data == C_KEY_COLOUR);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_rom_arbiter
// Brief   : Directed + randomized bench for sprite_rom_arbiter with a ROM
//           stand-in and a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

  localparam int N     = 4;
  localparam int AW    = 19;
  localparam int DEPTH = 1024;
  localparam int LAT   = 1;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            frame_start = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_addr;
  logic [23:0]     rom_data = '0;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [23:0]     rsp_data;
  logic            rsp_err;
`ifdef TRANSPARENT_KEY_EN
  logic            rsp_transp;
`endif

  sprite_rom_arbiter #(.N_REQ(N), .AW(AW), .DEPTH(DEPTH), .ROM_LAT(LAT)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_start(frame_start),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
`ifdef TRANSPARENT_KEY_EN
    ,
    .rsp_transp (rsp_transp)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_word(input logic [AW-1:0] a);
    logic [31:0] w;
    if (a == AW'(7)) return 24'hFF0000;
    if (a == AW'(8)) return 24'h142608;
    w = 32'(a) * 32'h0019_660D + 32'h3C6E_F35F;
    return w[27:4];
  endfunction

  // Registered-read ROM stand-in
  always @(posedge Clk) rom_data <= rom_word(rom_addr);

  typedef struct {
    int            due;
    int            id;
    logic [AW-1:0] addr;
  } item_t;

  item_t         q[$];
  int            checks = 0;
  int            errors = 0;
  int            edge_cnt = 0;
  int            m_ptr = 0;
  logic [AW-1:0] m_last = '0;
  logic [AW-1:0] addr [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic check_rsp();
    item_t it;
    logic  e;
    if (q.size() > 0 && q[0].due == edge_cnt) begin
      it = q.pop_front();
      e  = (32'(it.addr) >= DEPTH);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(it.id));
      chk("rsp_err", 32'(rsp_err), 32'(e));
      chk("rsp_data", 32'(rsp_data), e ? 32'd0 : 32'(rom_word(it.addr)));
`ifdef TRANSPARENT_KEY_EN
      chk("rsp_transp", 32'(rsp_transp), 32'(!e && rom_word(it.addr) == 24'hFF0000));
`endif
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
`ifdef TRANSPARENT_KEY_EN
      chk("rsp_transp_idle", 32'(rsp_transp), 32'd0);
`endif
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic fs);
    int g;
    req_valid   = v;
    frame_start = fs;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
    @(negedge Clk);
    g = model_grant(m_ptr, v);
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("rom_addr", 32'(rom_addr), (g >= 0) ? 32'(addr[g]) : 32'(m_last));
    check_rsp();
    @(posedge Clk);
    edge_cnt++;
    if (g >= 0) begin
      q.push_back('{due: edge_cnt + LAT - 1, id: g, addr: addr[g]});
      m_last = addr[g];
      m_ptr  = (g + 1) % N;
    end
    if (fs) m_ptr = 0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) addr[i] = AW'(100 + i);
    req_valid = '1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Single requester
    addr[2] = AW'(5);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // Out-of-range boundary
    addr[0] = AW'(1024);
    step(4'b0001, 1'b0);
    addr[0] = AW'(1023);
    step(4'b0001, 1'b0);
    addr[0] = '1;
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);

    // Key colour and a non-key colour
    addr[1] = AW'(7);
    step(4'b0010, 1'b0);
    addr[1] = AW'(8);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);

    // frame_start while req 3 granted
    step(4'b0100, 1'b0);
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);

    // Reset with requests in flight
    for (int i = 0; i < N; i++) addr[i] = AW'(200 + i);
    repeat (3) step(4'b1111, 1'b0);
    Reset = 1'b1;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_rsp_err", 32'(rsp_err), 32'd0);
    chk("midreset_rsp_id", 32'(rsp_id), 32'd0);
    chk("midreset_ready", 32'(req_ready), 32'd0);
    q.delete();
    m_ptr  = 0;
    m_last = '0;
    repeat (2) begin
      @(negedge Clk);
      chk("inreset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("inreset_ready", 32'(req_ready), 32'd0);
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (8) step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       addr[i] = AW'(DEPTH - 1 + int'($urandom_range(0, 1)));
          1:       addr[i] = AW'($urandom_range(0, 15));
          default: addr[i] = AW'($urandom_range(0, 1200));
        endcase
      end
      step(N'($urandom), ($urandom_range(0, 15) == 0));
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
